// File: rtl/snake_game_sequencer.sv
// Move-tick prescaler, debounced turn arbitration and play/message FSM for the snake datapath.
// Define SNAKE_PAUSE_EN to let a simultaneous two-key press toggle a paused sub-state.

module snake_key_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Raw buttons are asynchronous to clockInp, so sample through two flops first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    accept  = 1'b0;
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        accept  = 1'b1;
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_o = accept & ~sync_q[1];
endmodule

module snake_game_sequencer #(
  parameter int CLK_PER_UNIT = 20000,
  parameter int BASE_DELAY   = 20,
  parameter int MIN_DELAY    = 10,
  parameter int MSG_TICKS    = 20,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic       clockInp,
  input  logic       resetInp_n,
  input  logic [1:0] KEY,
  input  logic       game_won,
  input  logic       game_lost,
  output logic       move_tick,
  output logic [1:0] turn_cmd,
  output logic [1:0] msg_sel,
  output logic       game_reset,
  output logic [4:0] delay_units
);
  localparam int          MW       = $clog2(MSG_TICKS + 1);
  localparam logic [23:0] TERM_RST = 24'(CLK_PER_UNIT * BASE_DELAY - 1);
  localparam logic [1:0]  T_NONE   = 2'b00;
  localparam logic [1:0]  T_RIGHT  = 2'b01;
  localparam logic [1:0]  T_LEFT   = 2'b10;

  typedef enum logic [1:0] {PLAY, WIN_MSG, LOSE_MSG, RESTART} state_e;

  state_e        state_q, state_d;
  logic [23:0]   cnt_q, cnt_d, term_q, term_d;
  logic [4:0]    delay_q, delay_d;
  logic [1:0]    pend_q, pend_d, turn_q, turn_d, ev;
  logic          tick_q, tick_d, wrap;
  logic [MW-1:0] msg_cnt_q, msg_cnt_d;
  logic [1:0]    press;
  logic          paused_q, pause_tgl;

  for (genvar i = 0; i < 2; i++) begin : g_key
    snake_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk_i  (clockInp),
      .rst_ni (resetInp_n),
      .key_i  (KEY[i]),
      .press_o(press[i])
    );
  end

`ifdef SNAKE_PAUSE_EN
  assign pause_tgl = (state_q == PLAY) && press[0] && press[1];

  always_ff @(posedge clockInp or negedge resetInp_n) begin
    if (!resetInp_n)          paused_q <= 1'b0;
    else if (state_q != PLAY) paused_q <= 1'b0;
    else if (pause_tgl)       paused_q <= ~paused_q;
  end
`else
  assign pause_tgl = 1'b0;
  assign paused_q  = 1'b0;
`endif

  always_ff @(posedge clockInp or negedge resetInp_n) begin
    if (!resetInp_n) begin
      state_q   <= PLAY;
      cnt_q     <= '0;
      term_q    <= TERM_RST;
      delay_q   <= 5'(BASE_DELAY);
      pend_q    <= T_NONE;
      turn_q    <= T_NONE;
      tick_q    <= 1'b0;
      msg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      term_q    <= term_d;
      delay_q   <= delay_d;
      pend_q    <= pend_d;
      turn_q    <= turn_d;
      tick_q    <= tick_d;
      msg_cnt_q <= msg_cnt_d;
    end
  end

  // The period is re-latched only at a wrap, so a delay change never rescales a running period.
  always_comb begin
    wrap   = !paused_q && (cnt_q == term_q);
    cnt_d  = cnt_q;
    term_d = term_q;
    tick_d = wrap;
    turn_d = turn_q;
    if (!paused_q) cnt_d = wrap ? '0 : cnt_q + 24'd1;
    if (wrap) begin
      term_d = 24'(CLK_PER_UNIT) * {19'd0, delay_q} - 24'd1;
      turn_d = (state_q == PLAY) ? pend_q : T_NONE;
    end
  end

  always_comb begin
    ev = T_NONE;
    if (!pause_tgl) begin
      if (press[0])      ev = T_RIGHT;
      else if (press[1]) ev = T_LEFT;
    end
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    pend_d    = pend_q;
    msg_cnt_d = msg_cnt_q;
    case (state_q)
      PLAY: begin
        if (!paused_q) begin
          if (wrap)                 pend_d = ev;
          else if (pend_q == T_NONE) pend_d = ev;
        end
        msg_cnt_d = '0;
        if (game_lost) begin
          state_d = LOSE_MSG;
          delay_d = 5'(BASE_DELAY);
        end else if (game_won) begin
          state_d = WIN_MSG;
          if (delay_q > 5'(MIN_DELAY)) delay_d = delay_q - 5'd1;
        end
      end
      WIN_MSG, LOSE_MSG: begin
        pend_d = T_NONE;
        if (tick_q) begin
          if (msg_cnt_q == MW'(MSG_TICKS - 1)) begin
            state_d   = RESTART;
            msg_cnt_d = '0;
          end else begin
            msg_cnt_d = msg_cnt_q + MW'(1);
          end
        end
      end
      default: begin
        pend_d  = T_NONE;
        state_d = PLAY;
      end
    endcase
  end

  assign move_tick   = tick_q;
  assign turn_cmd    = (tick_q && state_q == PLAY) ? turn_q : T_NONE;
  assign msg_sel     = (state_q == WIN_MSG) ? 2'b01 : (state_q == LOSE_MSG) ? 2'b10 : 2'b00;
  assign game_reset  = (state_q == RESTART);
  assign delay_units = delay_q;
endmodule
